// File: rtl/prv32_lsu.sv
// prv32_lsu -- RV32I load/store unit with a single outstanding bus access.
//
// Accepts one load or store from execute while IDLE, checks it for an illegal
// funct3 or a misaligned address, and either reports a fault or issues one
// word-aligned bus request that is held until mem_ack or until TIMEOUT cycles
// pass. Loads are formatted (byte/half select, sign/zero extension) and
// returned as a one-cycle writeback pulse.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ex_valid/ex_load/ex_store  op offer from execute (exactly one kind)
//   ex_funct3, ex_addr         width/sign code, effective address
//   ex_wdata, ex_rd            store source data, load destination register
//   ex_ready                   LSU can accept (IDLE only)
//   mem_req/mem_we/mem_addr    bus request, write enable, word address
//   mem_wdata/mem_wstrb        lane-aligned store data and byte enables
//   mem_ack/mem_rdata          bus completion and read word
//   wb_valid/wb_rd/wb_data     load writeback pulse
//   err_valid/err_cause/err_addr  fault pulse: 01 misaligned, 10 timeout,
//                                 11 illegal funct3
module prv32_lsu #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        ex_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_valid,
  output logic [1:0]  err_cause,
  output logic [31:0] err_addr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
    if (is_load)
      f3_legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                 (f3 == 3'b100) || (f3 == 3'b101);
    else
      f3_legal = (f3[2] == 1'b0) && (f3[1:0] != 2'b11);
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b00:   store_data = {4{w[7:0]}};
      2'b01:   store_data = {2{w[15:0]}};
      default: store_data = w;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   store_strb = 4'b0001 << a;
      2'b01:   store_strb = 4'b0011 << a;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Byte lane chosen by addr[1:0], half lane by addr[1]; signed locals make
  // the widening cast sign-extend for lb/lh.
  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0]        bw;
    logic [31:0]        hw;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    bw = w >> {a, 3'b000};
    hw = w >> {a[1], 4'b0000};
    sb = signed'(bw[7:0]);
    sh = signed'(hw[15:0]);
    case (f3)
      3'b000:  load_fmt = 32'(sb);
      3'b001:  load_fmt = 32'(sh);
      3'b100:  load_fmt = {24'b0, bw[7:0]};
      3'b101:  load_fmt = {16'b0, hw[15:0]};
      default: load_fmt = w;
    endcase
  endfunction

  logic [0:0]       state;
  logic             alive;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_p0;
  logic [2:0]       f3_p0;
  logic             store_p0;
  logic [4:0]       rd_p0;
  logic [31:0]      wdata_p0;
  logic [3:0]       wstrb_p0;

  logic busy, accept, illegal, misal, fault, done, expire;

  always_comb begin
    busy    = (state == BUSY);
    accept  = ex_valid & ex_ready & (ex_load ^ ex_store);
    illegal = ~f3_legal(ex_funct3, ex_load);
    misal   = misaligned(ex_funct3[1:0], ex_addr[1:0]);
    fault   = illegal | misal;
    done    = busy & mem_ack;
    expire  = busy & ~mem_ack & (cnt == CNT_LAST);
  end

  // alive holds ex_ready low until the first clock after reset release.
  assign ex_ready  = alive & ~busy;
  assign mem_req   = busy;
  assign mem_we    = store_p0;
  assign mem_addr  = {addr_p0[31:2], 2'b00};
  assign mem_wdata = wdata_p0;
  assign mem_wstrb = wstrb_p0;

  // Control: FSM, wait counter and the writeback/fault pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alive     <= 1'b0;
      cnt       <= '0;
      wb_valid  <= 1'b0;
      err_valid <= 1'b0;
    end else begin
      alive     <= 1'b1;
      wb_valid  <= done & ~store_p0;
      err_valid <= (accept & fault) | expire;
      case (state)
        IDLE: begin
          if (accept && !fault) begin
            state <= BUSY;
            cnt   <= '0;
          end
        end
        default: begin
          if (done || expire)
            state <= IDLE;
          else
            cnt <= cnt + 1'b1;
        end
      endcase
    end
  end

  // Stage p0: request latched at acceptance; also writeback/fault payloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_p0   <= '0;
      f3_p0     <= '0;
      store_p0  <= 1'b0;
      rd_p0     <= '0;
      wdata_p0  <= '0;
      wstrb_p0  <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      err_cause <= '0;
      err_addr  <= '0;
    end else begin
      if (accept) begin
        addr_p0  <= ex_addr;
        f3_p0    <= ex_funct3;
        store_p0 <= ex_store;
        rd_p0    <= ex_rd;
        wdata_p0 <= store_data(ex_funct3[1:0], ex_wdata);
        wstrb_p0 <= store_strb(ex_funct3[1:0], ex_addr[1:0]);
      end
      if (done) begin
        wb_rd   <= rd_p0;
        wb_data <= load_fmt(f3_p0, addr_p0[1:0], mem_rdata);
      end
      if (accept && fault) begin
        err_cause <= illegal ? 2'b11 : 2'b01;
        err_addr  <= ex_addr;
      end else if (expire) begin
        err_cause <= 2'b10;
        err_addr  <= addr_p0;
      end
    end
  end

endmodule

// File: tb/tb_prv32_lsu.sv
module tb_prv32_lsu;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_load;
  logic        ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_valid;
  logic [1:0]  err_cause;
  logic [31:0] err_addr;

  int tests;
  int fails;

  prv32_lsu #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .ex_ready(ex_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_valid(err_valid), .err_cause(err_cause), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Present an op at the current negedge; returns at the negedge after the
  // accepting rising edge with ex_valid dropped.
  task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd);
    ex_valid  = 1'b1;
    ex_load   = ld;
    ex_store  = st;
    ex_funct3 = f3;
    ex_addr   = a;
    ex_wdata  = wd;
    ex_rd     = rd;
    @(negedge clk);
    ex_valid  = 1'b0;
    ex_load   = 1'b0;
    ex_store  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    tests++;
    if ({ex_ready, mem_req, mem_we, mem_wstrb, wb_valid, err_valid} !== 9'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0", {ex_ready, mem_req, mem_we, mem_wstrb, wb_valid, err_valid});
    end
    tests++;
    if ({mem_addr, mem_wdata, wb_data, wb_rd, err_cause, err_addr} !== 135'b0) begin
      fails++;
      $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, wb_data, wb_rd, err_cause, err_addr});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests++;
    if (ex_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: got %b want 0", ex_ready);
    end
    @(negedge clk);
    tests++;
    if (ex_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_release: got %b want 1", ex_ready);
    end
  endtask

  task automatic test_lb();
    drive_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd5);
    tests++;
    if ({mem_req, mem_we, ex_ready, mem_addr} !== {3'b100, 32'h0000_1000}) begin
      fails++;
      $display("FAIL lb_req: got req=%b we=%b rdy=%b addr=%h want 1 0 0 00001000",
               mem_req, mem_we, ex_ready, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h80FF_FF7F;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({wb_valid, wb_rd, wb_data, ex_ready, mem_req, err_valid} !== {1'b1, 5'd5, 32'hFFFF_FF80, 3'b100}) begin
      fails++;
      $display("FAIL lb_wb: got v=%b rd=%0d data=%h rdy=%b req=%b err=%b want 1 5 ffffff80 1 0 0",
               wb_valid, wb_rd, wb_data, ex_ready, mem_req, err_valid);
    end
    @(negedge clk);
    tests++;
    if (wb_valid !== 1'b0) begin
      fails++;
      $display("FAIL lb_pulse: got wb_valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_sh();
    logic stable;
    drive_op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd0);
    tests++;
    if ({mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr} !== {2'b11, 4'b1100, 32'hABCD_ABCD, 32'h0000_2000}) begin
      fails++;
      $display("FAIL sh_req: got req=%b we=%b strb=%b wdata=%h addr=%h want 1 1 1100 abcdabcd 00002000",
               mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr);
    end
    stable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({mem_req, mem_we, mem_wstrb, mem_wdata, mem_addr} !== {2'b11, 4'b1100, 32'hABCD_ABCD, 32'h0000_2000})
        stable = 1'b0;
    end
    tests++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL sh_stable: got stable=%b want 1", stable);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({wb_valid, err_valid, mem_req, ex_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL sh_done: got wbv=%b errv=%b req=%b rdy=%b want 0 0 0 1",
               wb_valid, err_valid, mem_req, ex_ready);
    end
  endtask

  task automatic test_misalign();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 5'd7);
    tests++;
    if ({err_valid, err_cause, err_addr, mem_req, ex_ready, wb_valid} !== {3'b101, 32'h6, 3'b010}) begin
      fails++;
      $display("FAIL lw_misalign: got errv=%b cause=%b addr=%h req=%b rdy=%b wbv=%b want 1 01 00000006 0 1 0",
               err_valid, err_cause, err_addr, mem_req, ex_ready, wb_valid);
    end
    @(negedge clk);
    tests++;
    if ({err_valid, mem_req} !== 2'b00) begin
      fails++;
      $display("FAIL misalign_pulse: got errv=%b req=%b want 0 0", err_valid, mem_req);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd9);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      cycles++;
      @(negedge clk);
    end
    tests++;
    if (cycles !== 15) begin
      fails++;
      $display("FAIL timeout_len: got %0d cycles want 15", cycles);
    end
    tests++;
    if ({err_valid, err_cause, err_addr, ex_ready, wb_valid} !== {3'b110, 32'h0000_3000, 2'b10}) begin
      fails++;
      $display("FAIL timeout_err: got errv=%b cause=%b addr=%h rdy=%b wbv=%b want 1 10 00003000 1 0",
               err_valid, err_cause, err_addr, ex_ready, wb_valid);
    end
  endtask

  task automatic test_ack_at_timeout();
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd3);
    repeat (14) @(negedge clk);
    tests++;
    if (mem_req !== 1'b1) begin
      fails++;
      $display("FAIL ack_last_req: got req=%b want 1", mem_req);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({wb_valid, wb_data, err_valid, mem_req} !== {1'b1, 32'hDEAD_BEEF, 2'b00}) begin
      fails++;
      $display("FAIL ack_wins: got wbv=%b data=%h errv=%b req=%b want 1 deadbeef 0 0",
               wb_valid, wb_data, err_valid, mem_req);
    end
  endtask

  task automatic test_illegal_then_lhu();
    drive_op(1'b0, 1'b1, 3'b100, 32'h0000_5000, 32'h1, 5'd0);
    tests++;
    if ({err_valid, err_cause, err_addr, mem_req} !== {3'b111, 32'h0000_5000, 1'b0}) begin
      fails++;
      $display("FAIL st_illegal: got errv=%b cause=%b addr=%h req=%b want 1 11 00005000 0",
               err_valid, err_cause, err_addr, mem_req);
    end
    // Illegal funct3 with a misaligned word address still reports 11.
    drive_op(1'b1, 1'b0, 3'b110, 32'h0000_5003, 32'h0, 5'd1);
    tests++;
    if ({err_valid, err_cause, mem_req} !== 4'b1110) begin
      fails++;
      $display("FAIL illegal_priority: got errv=%b cause=%b req=%b want 1 11 0",
               err_valid, err_cause, mem_req);
    end
    drive_op(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 5'd12);
    tests++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h0000_4000}) begin
      fails++;
      $display("FAIL lhu_req: got req=%b addr=%h want 1 00004000", mem_req, mem_addr);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h8001_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({wb_valid, wb_rd, wb_data} !== {1'b1, 5'd12, 32'h0000_8001}) begin
      fails++;
      $display("FAIL lhu_wb: got v=%b rd=%0d data=%h want 1 12 00008001", wb_valid, wb_rd, wb_data);
    end
    drive_op(1'b1, 1'b0, 3'b001, 32'h0000_4002, 32'h0, 5'd13);
    mem_ack   = 1'b1;
    mem_rdata = 32'h8001_0000;
    @(negedge clk);
    mem_ack = 1'b0;
    tests++;
    if ({wb_valid, wb_data} !== {1'b1, 32'hFFFF_8001}) begin
      fails++;
      $display("FAIL lh_wb: got v=%b data=%h want 1 ffff8001", wb_valid, wb_data);
    end
    // Both kinds high is ignored.
    drive_op(1'b1, 1'b1, 3'b010, 32'h0000_8000, 32'h0, 5'd2);
    tests++;
    if ({mem_req, err_valid, ex_ready} !== 3'b001) begin
      fails++;
      $display("FAIL both_kinds: got req=%b errv=%b rdy=%b want 0 0 1", mem_req, err_valid, ex_ready);
    end
  endtask

  task automatic test_reset_busy();
    logic seen;
    drive_op(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd4);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_req, ex_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_busy: got req=%b rdy=%b want 0 0", mem_req, ex_ready);
    end
    mem_ack   = 1'b1;
    mem_rdata = 32'h1111_1111;
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_valid || err_valid || mem_req) seen = 1'b1;
    end
    mem_ack = 1'b0;
    tests++;
    if ({seen, ex_ready} !== 2'b01) begin
      fails++;
      $display("FAIL after_reset_quiet: got pulse=%b rdy=%b want 0 1", seen, ex_ready);
    end
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    ex_valid  = 1'b0;
    ex_load   = 1'b0;
    ex_store  = 1'b0;
    ex_funct3 = 3'b000;
    ex_addr   = 32'h0;
    ex_wdata  = 32'h0;
    ex_rd     = 5'd0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    test_reset();
    test_lb();
    test_sh();
    test_misalign();
    test_timeout();
    test_ack_at_timeout();
    test_illegal_then_lhu();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prv32_lsu.md
PRV32_LSU -- requirements
Module: prv32_lsu

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum cycles mem_req may stay high without mem_ack before an access fault.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 ex_valid  in  1  execute stage presents a memory op.
REQ-005 ex_load, ex_store  in  1 each  op kind; both high is illegal.
REQ-006 ex_funct3  in  3  RV32I width/sign code.
REQ-007 ex_addr  in  32  effective address (ALU sum result).
REQ-008 ex_wdata  in  32  store source (rs2).
REQ-009 ex_rd  in  5  load destination register.
REQ-010 ex_ready  out  1  LSU can accept; high only in IDLE.
REQ-011 mem_req, mem_we  out  1 each  bus request, write enable.
REQ-012 mem_addr  out  32  word-aligned address ({ex_addr[31:2],2'b00}).
REQ-013 mem_wdata  out  32; mem_wstrb  out  4  lane-aligned write data and byte enables.
REQ-014 mem_ack  in  1; mem_rdata  in  32  bus completion and read word (valid with mem_ack).
REQ-015 wb_valid  out  1; wb_rd  out  5; wb_data  out  32  load writeback, one-cycle pulse.
REQ-016 err_valid  out  1; err_cause  out  2; err_addr  out  32  fault report, one-cycle pulse.

Function
REQ-017 FSM states IDLE, BUSY; an op is accepted when ex_valid & ex_ready & (ex_load ^ ex_store).
REQ-018 ex_valid with neither or both of ex_load/ex_store is ignored; the FSM stays in IDLE.
REQ-019 On acceptance, latch addr, funct3, kind, rd and formatted store data/strobes; check faults in the same cycle.
REQ-020 Legal load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; legal store funct3: 000 sb, 001 sh, 010 sw; other codes give err_cause 2'b11, and no bus access occurs.
REQ-021 Misalignment (word: addr[1:0]!=0; half: addr[0]!=0) gives err_cause 2'b01 with no bus access; illegal funct3 takes priority over misalignment.
REQ-022 A fault at acceptance pulses err_valid for one cycle, one cycle after acceptance, with err_addr=ex_addr; the FSM stays in IDLE.
REQ-023 A clean acceptance enters BUSY next cycle; mem_req=1 throughout BUSY, and mem_addr/mem_we/mem_wdata/mem_wstrb stay stable until mem_ack.
REQ-024 Store strobes: sb 4'b0001<<addr[1:0]; sh 4'b0011<<addr[1:0]; sw 4'b1111.
REQ-025 Store data: sb {4{wdata[7:0]}}; sh {2{wdata[15:0]}}; sw wdata.
REQ-026 mem_ack in BUSY returns the FSM to IDLE next cycle; for a load, wb_valid pulses that same next cycle.
REQ-027 Load data: select the byte/half by addr[1:0] (addr[1] for half); lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word through.
REQ-028 Minimum latency: acceptance at cycle N, mem_req at N+1, mem_ack at N+1 earliest, wb_valid and ex_ready at N+2.
REQ-029 The wait counter clears on entering BUSY and increments each BUSY cycle without mem_ack.
REQ-030 On reaching TIMEOUT, the FSM returns to IDLE, drops mem_req, pulses err_valid with cause 2'b10 and err_addr equal to the latched address, and asserts no wb_valid.
REQ-031 If mem_ack coincides with the timeout cycle, mem_ack wins: normal completion and no error.
REQ-032 Stores never assert wb_valid; wb_valid and err_valid are never high together.
REQ-033 mem_ack outside BUSY is ignored.

Reset
REQ-034 rst_n low immediately forces IDLE and clears the counter.
REQ-035 rst_n low forces mem_req, mem_we, mem_wstrb, wb_valid and err_valid to 0, and mem_addr, mem_wdata, wb_data, wb_rd, err_cause and err_addr to 0.
REQ-036 rst_n low forces ex_ready to 0.
REQ-037 ex_ready rises the first clock after rst_n deasserts.
REQ-038 Reset in BUSY abandons the op with no writeback or error.

Verification
REQ-039 lb, addr 0x1003, mem_rdata 0x80FF_FF7F, ack on first BUSY cycle -> mem_addr 0x1000; wb_data 0xFFFF_FF80 at N+2.
REQ-040 sh, addr 0x2002, wdata 0x1234_ABCD -> mem_wstrb 4'b1100, mem_wdata 0xABCD_ABCD, mem_we 1, no wb_valid.
REQ-041 lw, addr 0x0000_0006 -> no mem_req; err_valid with cause 01 and err_addr 0x6 at N+1.
REQ-042 lw, mem_ack withheld, TIMEOUT=15 -> mem_req high exactly 15 cycles, then err cause 10 and ex_ready 1.
REQ-043 Store funct3 100 -> err cause 11, no bus access; then lhu addr 0x4002 with rdata 0x8001_0000 -> wb_data 0x0000_8001.
REQ-044 rst_n pulled low mid-BUSY -> mem_req 0 without a clock edge; no wb_valid/err_valid after release.
